// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline stage information in, stall/flush/forward controls out.
// The master modport is the pipeline datapath; the slave modport is the hazard controller.
// RegWriteE is carried so the non-forwarding build can see ALU writers sitting in EX.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] Rs1D, Rs2D;
    logic [REG_AW-1:0] Rs1E, Rs2E;
    logic [REG_AW-1:0] RdE, RdM, RdW;
    logic [1:0]        ResSrcE;
    logic              RegWriteE, RegWriteM, RegWriteW;
    logic              PCSrcE;
    logic              MemReqM, MemReadyM;
    logic              StallF, StallD, StallE, StallM;
    logic              FlushD, FlushE, FlushW;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              MemErr;
    logic [CNT_W-1:0]  StallCnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResSrcE,
               RegWriteE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemErr, StallCnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResSrcE,
               RegWriteE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemErr, StallCnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RISC-V pipeline.
// Stall/flush/forward controls are combinational; a RUN/MEMWAIT/ERR FSM sequences
// data-memory waits with timeout supervision, plus a saturating stall-cycle counter.
// Optional feature macro: HAZ_FWD_EN (EX-stage operand forwarding; only load-use stalls).
// Without it, every RAW dependency on EX/MEM producers stalls and forwarding stays 00.
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input logic               Clk,
    input logic               Rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int                WaitW     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [REG_AW-1:0] RegZero   = '0;
    localparam logic [CNT_W-1:0]  CntMax    = '1;
    localparam logic [WaitW-1:0]  WaitLimit = WaitW'(MEM_TIMEOUT);
    localparam logic [WaitW-1:0]  WaitOne   = WaitW'(1);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StErr     = 2'd2
    } hazState_e;

    hazState_e        stateReg, stateNext;
    logic [WaitW-1:0] waitCntReg, waitCntNext;
    logic [CNT_W-1:0] stallCntReg;
    logic             memMiss, dataHaz;
    logic             stallF, stallD, stallE, stallM;
    logic             flushD, flushE, flushW;
    logic [1:0]       fwdA, fwdB;

    assign memMiss = hz.MemReqM & ~hz.MemReadyM;

`ifdef HAZ_FWD_EN
    // With forwarding only a load in EX cannot supply its result in time.
    assign dataHaz = (hz.ResSrcE == 2'b01) && (hz.RdE != RegZero) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    // MEM result is younger than WB, so it wins; x0 is never forwarded.
    assign fwdA = (hz.RegWriteM && (hz.RdM != RegZero) && (hz.RdM == hz.Rs1E)) ? 2'b10 :
                  (hz.RegWriteW && (hz.RdW != RegZero) && (hz.RdW == hz.Rs1E)) ? 2'b01 : 2'b00;
    assign fwdB = (hz.RegWriteM && (hz.RdM != RegZero) && (hz.RdM == hz.Rs2E)) ? 2'b10 :
                  (hz.RegWriteW && (hz.RdW != RegZero) && (hz.RdW == hz.Rs2E)) ? 2'b01 : 2'b00;

    logic unusedFwdOn;
    assign unusedFwdOn = hz.RegWriteE;
`else
    // A source register depending on a producer still in EX or MEM must wait;
    // WB needs no stall because the register file writes before it reads.
    function automatic logic rawHit(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rdE,
                                    input logic [REG_AW-1:0] rdM, input logic wrE,
                                    input logic wrM);
        return (rs != RegZero) && (((rs == rdE) && wrE) || ((rs == rdM) && wrM));
    endfunction

    logic writesE;
    assign writesE = (hz.ResSrcE != 2'b00) | hz.RegWriteE;
    assign dataHaz = rawHit(hz.Rs1D, hz.RdE, hz.RdM, writesE, hz.RegWriteM) |
                     rawHit(hz.Rs2D, hz.RdE, hz.RdM, writesE, hz.RegWriteM);
    assign fwdA    = 2'b00;
    assign fwdB    = 2'b00;

    logic unusedFwdOff;
    assign unusedFwdOff = ^{hz.Rs1E, hz.Rs2E, hz.RdW, hz.RegWriteW};
`endif

    // State register and memory-wait counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stateReg   <= StRun;
            waitCntReg <= '0;
        end else begin
            stateReg   <= stateNext;
            waitCntReg <= waitCntNext;
        end
    end

    // Next state: enter MEMWAIT on a miss, leave on ready, trap in ERR on timeout.
    always_comb begin
        stateNext   = stateReg;
        waitCntNext = waitCntReg;
        case (stateReg)
            StRun: begin
                if (memMiss) begin
                    waitCntNext = WaitOne;
                    stateNext   = (WaitOne >= WaitLimit) ? StErr : StMemWait;
                end
            end
            StMemWait: begin
                if (hz.MemReadyM) begin
                    stateNext   = StRun;
                    waitCntNext = '0;
                end else begin
                    waitCntNext = waitCntReg + 1'b1;
                    if (waitCntNext >= WaitLimit) begin
                        stateNext = StErr;
                    end
                end
            end
            default: stateNext = StErr;
        endcase
    end

    // Outputs: a pending memory access freezes everything; once ready, the RUN
    // priorities are evaluated in the same cycle so a held branch is applied then.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        if ((stateReg == StErr) || ((stateReg == StMemWait) && !hz.MemReadyM) || memMiss) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (hz.PCSrcE) begin
            // The instruction a hazard would stall is on the wrong path anyway.
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (dataHaz) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stallCntReg <= '0;
        end else if (stallF && (stallCntReg != CntMax)) begin
            stallCntReg <= stallCntReg + 1'b1;
        end
    end

    assign hz.StallF    = stallF;
    assign hz.StallD    = stallD;
    assign hz.StallE    = stallE;
    assign hz.StallM    = stallM;
    assign hz.FlushD    = flushD;
    assign hz.FlushE    = flushE;
    assign hz.FlushW    = flushW;
    assign hz.ForwardAE = fwdA;
    assign hz.ForwardBE = fwdB;
    assign hz.MemErr    = (stateReg == StErr);
    assign hz.StallCnt  = stallCntReg;
endmodule
